// File: rtl/dgldpc_pkg.sv
// Shared types and constants for the DG-LDPC VNU scheduling slice.
package dgldpc_pkg;

    localparam int ITER_W         = 4;
    localparam int VNU_LAT_STAGES = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Zero or out-of-range requests fall back to the hard iteration ceiling.
    function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] req,
                                                     input int max_iter);
        if (req == '0 || int'(req) > max_iter) begin
            return ITER_W'(max_iter);
        end
        return req;
    endfunction

endpackage

// File: rtl/dgldpc_vnu_wb_pipe.sv
// Write-back tracker: carries {valid, addr} of every issued read through the
// fixed RAM+VNU latency so the result lands on the matching VN address.
module dgldpc_vnu_wb_pipe #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_empty
);

    logic [DEPTH-1:0]  valid_sr;
    logic [ADDR_W-1:0] addr_sr [DEPTH];

    // Addresses are cleared along with the valids so the write address reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            valid_sr   <= {valid_sr[DEPTH-2:0], i_valid};
            addr_sr[0] <= i_addr;
            for (int i = 1; i < DEPTH; i++) begin
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    assign o_valid = valid_sr[DEPTH-1];
    assign o_addr  = addr_sr[DEPTH-1];
    assign o_empty = (valid_sr == '0);

endmodule

// File: rtl/dgldpc_vnu_scheduler.sv
// Shuffled-schedule VNU sequencer: streams VN reads, tracks write-back latency,
// drains between iterations and terminates on syndrome success or iteration limit.
module dgldpc_vnu_scheduler
    import dgldpc_pkg::*;
#(
    parameter int N_VN     = 64,
    parameter int MAX_ITER = 8,
    parameter int RD_LAT   = 1,
    parameter int VNU_LAT  = VNU_LAT_STAGES,
    localparam int ADDR_W  = $clog2(N_VN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ITER_W-1:0] i_max_iter,
    input  logic              i_stall,
    input  logic              i_synd_ok,
    output logic              o_busy,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [ITER_W-1:0] o_iter,
    output logic              o_last_iter,
    output logic              o_done,
    output logic              o_success
);

    localparam int                DEPTH     = RD_LAT + VNU_LAT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_VN - 1);

    state_t            state;
    logic [ITER_W-1:0] iter_lim;
    logic              pipe_empty;
    logic              final_wr;

    assign o_rd_en     = (state == ST_ISSUE) && !i_stall;
    assign o_busy      = (state == ST_ISSUE) || (state == ST_DRAIN) || (state == ST_CHECK);
    assign o_done      = (state == ST_DONE);
    assign o_last_iter = o_busy && (o_iter == (iter_lim - ITER_W'(1)));
    assign final_wr    = o_wr_en && (o_wr_addr == LAST_ADDR);

    dgldpc_vnu_wb_pipe #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wb_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (o_rd_en),
        .i_addr  (o_rd_addr),
        .o_valid (o_wr_en),
        .o_addr  (o_wr_addr),
        .o_empty (pipe_empty)
    );

    // CHECK always follows the final write-back, so the checker sees the whole iteration's RAM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            o_rd_addr <= '0;
            o_iter    <= '0;
            iter_lim  <= '0;
            o_success <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_ISSUE;
                        o_rd_addr <= '0;
                        o_iter    <= '0;
                        iter_lim  <= clamp_iter(i_max_iter, MAX_ITER);
                        o_success <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (o_rd_en) begin
                        if (o_rd_addr == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end else begin
                            o_rd_addr <= o_rd_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (final_wr) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (pipe_empty) begin
                        if (i_synd_ok || o_last_iter) begin
                            state     <= ST_DONE;
                            o_success <= i_synd_ok;
                        end else begin
                            state     <= ST_ISSUE;
                            o_iter    <= o_iter + ITER_W'(1);
                            o_rd_addr <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
